// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel edge stream: gray coefficients, output modes, FSM states.
package sobel_pkg;
  localparam int unsigned GRAY_R = 77;
  localparam int unsigned GRAY_G = 150;
  localparam int unsigned GRAY_B = 29;

  typedef enum logic [1:0] {
    MODE_BIN  = 2'd0,
    MODE_MAG  = 2'd1,
    MODE_GRAY = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/line_buffer_2row.sv
// Two circular gray-line stores sharing one column pointer; row1 = previous line, row2 = the line before.
module line_buffer_2row #(
  parameter  int IMG_WIDTH = 640,
  parameter  int PIX_W     = 8,
  localparam int CW        = $clog2(IMG_WIDTH)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [CW-1:0]    col_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] tap1_o,
  output logic [PIX_W-1:0] tap2_o
);
  logic [PIX_W-1:0] row1_mem [IMG_WIDTH];
  logic [PIX_W-1:0] row2_mem [IMG_WIDTH];

  assign tap1_o = row1_mem[col_i];
  assign tap2_o = row2_mem[col_i];

  always_ff @(posedge clk) begin
    if (en_i) begin
      row1_mem[col_i] <= din_i;
      row2_mem[col_i] <= row1_mem[col_i];
    end
  end
endmodule

// File: rtl/sobel_edge_stream.sv
// Raster RGB -> gray -> 3x3 Sobel stream with binary/magnitude/gray output and frame markers.
module sobel_edge_stream
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int PIX_W         = 8,
  parameter int DEF_THRESHOLD = 150
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             din_sof,
  input  logic [PIX_W-1:0] r_data,
  input  logic [PIX_W-1:0] g_data,
  input  logic [PIX_W-1:0] b_data,
  input  logic [1:0]       mode,
  input  logic [PIX_W+2:0] threshold,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [PIX_W-1:0] edge_data,
  output logic             dout_sof,
  output logic             dout_eol,
  output logic             frame_err
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(IMG_WIDTH + 1);
  localparam int TW = PIX_W + 3;
  localparam int GW = PIX_W + 4;
  localparam int SW = PIX_W + 8;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FL_LAST  = FW'(IMG_WIDTH);

  state_e           state_q;
  logic [CW-1:0]    col_q, px_col, s1_col_q, ocol_q, wcol_q;
  logic [RW-1:0]    row_q, px_row, orow_q, wrow_q;
  logic [FW-1:0]    fl_q;
  mode_e            mode_q, win_mode_q;
  logic [TW-1:0]    thr_q, win_thr_q;
  logic             en, acc, sof_acc, kill, issue_px, issue_pad, px_emit, shift;
  logic [SW-1:0]    gray_sum;
  logic             s1_vld_q, s1_emit_q, win_vld_q;
  logic [PIX_W-1:0] s1_gray_q, tap1, tap2, pix_out;
  logic [2:0][2:0][PIX_W-1:0] w_q;
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]    ax, ay;
  logic [TW-1:0]    mag;
  logic             border;
  logic             dout_valid_q, dout_sof_q, dout_eol_q, frame_err_q;
  logic [PIX_W-1:0] edge_q;

  // Whole pipeline moves in lockstep; it only freezes while the output is stalled.
  assign en        = !dout_valid_q | dout_ready;
  assign din_ready = rst_n & (state_q != FLUSH) & en;
  assign acc       = din_valid & din_ready;
  assign sof_acc   = acc & din_sof;
  assign kill      = sof_acc & (state_q == RUN);
  assign issue_px  = acc & ((state_q == RUN) | din_sof);
  assign issue_pad = (state_q == FLUSH) & en;
  assign px_col    = sof_acc ? '0 : col_q;
  assign px_row    = sof_acc ? '0 : row_q;
  // Output k appears once input k+W+1 is in the window, i.e. from pixel (1,1) onward.
  assign px_emit   = ((px_row != '0) && (px_col != '0)) || (px_row > RW'(1));
  assign gray_sum  = SW'(GRAY_R) * SW'(r_data) + SW'(GRAY_G) * SW'(g_data)
                   + SW'(GRAY_B) * SW'(b_data);
  assign shift     = en & s1_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      fl_q    <= '0;
      mode_q  <= MODE_BIN;
      thr_q   <= TW'(DEF_THRESHOLD);
    end else if (sof_acc) begin
      state_q <= RUN;
      col_q   <= CW'(1);
      row_q   <= '0;
      mode_q  <= mode_e'(mode);
      thr_q   <= threshold;
    end else begin
      case (state_q)
        RUN: if (acc) begin
          if (col_q == COL_LAST) begin
            col_q <= '0;
            if (row_q == ROW_LAST) begin
              state_q <= FLUSH;
              fl_q    <= '0;
            end else row_q <= row_q + 1'b1;
          end else col_q <= col_q + 1'b1;
        end
        FLUSH: if (en) begin
          col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
          fl_q  <= fl_q + 1'b1;
          if (fl_q == FL_LAST) begin
            state_q <= IDLE;
            col_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_emit_q <= 1'b0;
      s1_col_q  <= '0;
      s1_gray_q <= '0;
    end else if (en) begin
      s1_vld_q  <= issue_px | issue_pad;
      s1_emit_q <= issue_pad | px_emit;
      s1_col_q  <= issue_pad ? col_q : px_col;
      s1_gray_q <= issue_pad ? '0 : PIX_W'(gray_sum >> 8);
    end
  end

  line_buffer_2row #(.IMG_WIDTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb (
    .clk    (clk),
    .en_i   (shift),
    .col_i  (s1_col_q),
    .din_i  (s1_gray_q),
    .tap1_o (tap1),
    .tap2_o (tap2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q        <= '0;
      win_vld_q  <= 1'b0;
      wcol_q     <= '0;
      wrow_q     <= '0;
      ocol_q     <= '0;
      orow_q     <= '0;
      win_mode_q <= MODE_BIN;
      win_thr_q  <= TW'(DEF_THRESHOLD);
    end else begin
      if (shift) begin
        for (int r = 0; r < 3; r++) begin
          w_q[r][0] <= w_q[r][1];
          w_q[r][1] <= w_q[r][2];
        end
        w_q[0][2] <= tap2;
        w_q[1][2] <= tap1;
        w_q[2][2] <= s1_gray_q;
      end
      // Mode/threshold travel with the window so a new sof cannot retag the old frame's tail.
      if (en) begin
        win_vld_q  <= s1_vld_q & s1_emit_q & !kill;
        wcol_q     <= ocol_q;
        wrow_q     <= orow_q;
        win_mode_q <= mode_q;
        win_thr_q  <= thr_q;
      end
      if (sof_acc) begin
        ocol_q <= '0;
        orow_q <= '0;
      end else if (shift & s1_emit_q) begin
        if (ocol_q == COL_LAST) begin
          ocol_q <= '0;
          orow_q <= (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
        end else ocol_q <= ocol_q + 1'b1;
      end
    end
  end

  function automatic logic signed [GW-1:0] sx(input logic [PIX_W-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  always_comb begin
    gx = sx(w_q[0][2]) + (sx(w_q[1][2]) <<< 1) + sx(w_q[2][2])
       - sx(w_q[0][0]) - (sx(w_q[1][0]) <<< 1) - sx(w_q[2][0]);
    gy = sx(w_q[2][0]) + (sx(w_q[2][1]) <<< 1) + sx(w_q[2][2])
       - sx(w_q[0][0]) - (sx(w_q[0][1]) <<< 1) - sx(w_q[0][2]);
    ax = gx[GW-1] ? -gx : gx;
    ay = gy[GW-1] ? -gy : gy;
    mag = TW'(ax) + TW'(ay);
    border = (wrow_q == '0) || (wrow_q == ROW_LAST) || (wcol_q == '0) || (wcol_q == COL_LAST);
    pix_out = '0;
    case (win_mode_q)
      MODE_GRAY: pix_out = w_q[1][1];
      MODE_MAG:  if (!border) pix_out = (mag[TW-1:PIX_W] != '0) ? '1 : mag[PIX_W-1:0];
      default:   if (!border && (mag > win_thr_q)) pix_out = '1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid_q <= 1'b0;
      edge_q       <= '0;
      dout_sof_q   <= 1'b0;
      dout_eol_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q <= kill;
      if (en) begin
        dout_valid_q <= win_vld_q & !kill;
        if (win_vld_q) begin
          edge_q     <= pix_out;
          dout_sof_q <= (wcol_q == '0) && (wrow_q == '0);
          dout_eol_q <= (wcol_q == COL_LAST);
        end
      end
    end
  end

  assign dout_valid = dout_valid_q;
  assign edge_data  = edge_q;
  assign dout_sof   = dout_sof_q;
  assign dout_eol   = dout_eol_q;
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_sobel_edge_stream.sv
// Directed bench for sobel_edge_stream on an 8x4 frame: modes, thresholds, stalls, restart, reset.
module tb_sobel_edge_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        din_sof = 1'b0;
  logic [7:0]  r_data = '0, g_data = '0, b_data = '0;
  logic [1:0]  mode = '0;
  logic [10:0] threshold = 11'd150;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [7:0]  edge_data;
  logic        dout_sof, dout_eol, frame_err;

  int n_vec = 0, n_err = 0, n_ferr = 0;
  int cyc = 0, acc9 = 0, first_cyc = 0;
  bit seen_first = 0, rnd_rdy = 0, prev_stall = 0;
  logic [9:0] prev_out;
  logic [9:0] q[$];

  sobel_edge_stream #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .PIX_W(8), .DEF_THRESHOLD(150)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready), .din_sof(din_sof),
    .r_data(r_data), .g_data(g_data), .b_data(b_data), .mode(mode), .threshold(threshold),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .edge_data(edge_data),
    .dout_sof(dout_sof), .dout_eol(dout_eol), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    dout_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (dout_valid && dout_ready) begin
        q.push_back({edge_data, dout_sof, dout_eol});
        if (!seen_first) begin first_cyc = cyc; seen_first = 1; end
      end
      if (frame_err) n_ferr++;
      if (prev_stall) chk("stall_hold", {dout_valid, edge_data, dout_sof, dout_eol}, {1'b1, prev_out});
      if (dout_valid && !dout_ready) chk("stall_din_ready", 32'(din_ready), 0);
      prev_stall = dout_valid && !dout_ready;
      prev_out   = {edge_data, dout_sof, dout_eol};
    end
  end

  function automatic logic [7:0] pixv(input int kind, input int k);
    case (kind)
      0:       return 8'h80;
      1:       return (k % 8 < 4) ? 8'h00 : 8'hFF;
      default: return 8'(k * 8);
    endcase
  endfunction

  // Vertical edge gives |Gx|=4*255=1020, |Gy|=0 at interior cols 3 and 4; everything else is flat.
  function automatic logic [9:0] expv(input int kind, input int md, input int thr, input int k);
    int row = k / 8;
    int col = k % 8;
    logic inner;
    logic [7:0] v;
    inner = (kind == 1) && (row == 1 || row == 2) && (col == 3 || col == 4);
    if (md == 2)      v = pixv(kind, k);
    else if (md == 1) v = inner ? 8'hFF : 8'h00;
    else              v = (inner && 1020 > thr) ? 8'hFF : 8'h00;
    return {v, k == 0, col == 7};
  endfunction

  task automatic send_px(input logic [7:0] v, input logic sof);
    int b = 0;
    din_valid = 1'b1; din_sof = sof;
    r_data = v; g_data = v; b_data = v;
    @(negedge clk);
    while (!din_ready && b < 1000) begin @(negedge clk); b++; end
    if (!din_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: din_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    din_sof = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int b = 0;
    while (q.size() < n && b < 3000) begin @(posedge clk); b++; end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int kind, input int md, input int thr);
    chk({tag, "_count"}, q.size(), 32);
    for (int k = 0; k < 32 && k < q.size(); k++)
      chk($sformatf("%s_px%0d", tag, k), 32'(q[k]), 32'(expv(kind, md, thr, k)));
  endtask

  task automatic run_frame(input string tag, input int kind, input int md, input int thr);
    q.delete(); seen_first = 0;
    mode = 2'(md); threshold = 11'(thr);
    for (int k = 0; k < 32; k++) begin
      send_px(pixv(kind, k), k == 0);
      if (k == 0) begin
        mode = (md == 2) ? 2'd0 : 2'd2;
        threshold = 11'd0;
      end
      if (k == 9) acc9 = cyc;
    end
    din_valid = 1'b0;
    wait_outs(32);
    check_outs(tag, kind, md, thr);
  endtask

  initial begin
    int f0;
    #1 chk("reset_outs", {dout_valid, edge_data, dout_sof, dout_eol, frame_err, din_ready}, 0);
    #21 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {dout_valid, din_ready}, 2'b01);

    run_frame("flat_bin", 0, 0, 150);
    chk("first_latency", first_cyc - acc9, 2);
    run_frame("vedge_mag", 1, 1, 150);
    run_frame("vedge_thr1020", 1, 0, 1020);
    run_frame("vedge_thr1019", 1, 0, 1019);
    run_frame("ramp_gray", 2, 2, 150);

    rnd_rdy = 1;
    run_frame("ramp_gray_stall", 2, 2, 150);
    rnd_rdy = 0;
    repeat (3) @(posedge clk);
    #1;

    // Old frame restarted by a sof at raster index 13.
    q.delete();
    mode = 2'd0; threshold = 11'd150;
    for (int k = 0; k < 13; k++) send_px(pixv(0, k), k == 0);
    f0 = n_ferr;
    mode = 2'd1;
    send_px(pixv(1, 0), 1'b1);
    chk("restart_old_outs", q.size(), 2);
    q.delete();
    for (int k = 1; k < 32; k++) send_px(pixv(1, k), 1'b0);
    din_valid = 1'b0;
    wait_outs(32);
    check_outs("restart_frame", 1, 1, 0);
    chk("frame_err_pulses", n_ferr - f0, 1);

    // Reset asserted while the pipeline is flushing.
    mode = 2'd2;
    for (int k = 0; k < 32; k++) send_px(pixv(2, k), k == 0);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_active", 32'(dout_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_outs", {dout_valid, edge_data, dout_sof, dout_eol, frame_err, din_ready}, 0);
    repeat (2) @(posedge clk);
    #2 chk("rst_hold_outs", {dout_valid, edge_data, dout_sof, dout_eol, frame_err, din_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {dout_valid, din_ready}, 2'b01);
    q.delete();

    // A stray non-sof beat in IDLE must be dropped.
    send_px(8'hFF, 1'b0);
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_frame("post_rst_frame", 1, 1, 150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
